// File: rtl/load_port_arbiter.sv
// load_port_arbiter: round-robin arbiter for two load requesters sharing one
// fixed-latency, in-order, untagged memory load port. An ordered FIFO of
// {requester, tag} routes each returning block back to its owner.
module load_port_arbiter #(
  parameter int LATENCY = 100,
  parameter int DEPTH   = 128,
  parameter int TAG_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0Valid,
  output logic                         req0Ready,
  input  logic [15:0]                  req0Addr,
  input  logic [TAG_W-1:0]             req0Tag,
  input  logic                         req1Valid,
  output logic                         req1Ready,
  input  logic [15:0]                  req1Addr,
  input  logic [TAG_W-1:0]             req1Tag,
  output logic                         loadEnable,
  output logic [15:0]                  loadAddr,
  input  logic                         loadReady,
  input  logic [63:0]                  loadData,
  output logic                         rsp0Valid,
  output logic [63:0]                  rsp0Data,
  output logic [TAG_W-1:0]             rsp0Tag,
  output logic                         rsp1Valid,
  output logic [63:0]                  rsp1Data,
  output logic [TAG_W-1:0]             rsp1Tag,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic                         badAddr,
  output logic                         protoErr
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DC_W  = $clog2(LATENCY + 2);
  localparam logic [15:0] EMPTY_ADDR = 16'hFFFF;

  typedef enum logic {DRAIN, RUN} state_t;

  state_t            state, state_nxt;
  logic [DC_W-1:0]   drain_cnt, drain_cnt_nxt;
  logic              last_grant;

  // FIFO entry: {requester id, tag}
  logic [TAG_W:0]    fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic              run_st, can_grant;
  logic              gnt0, gnt1, gnt_any, gnt_id;
  logic [15:0]       gnt_addr;
  logic [TAG_W-1:0]  gnt_tag;
  logic              push, pop, spurious;
  logic              head_id;
  logic [TAG_W-1:0]  head_tag;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // State register and drain counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DRAIN;
      drain_cnt <= DC_W'(LATENCY + 1);
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next state: DRAIN counts down so returns from loads issued before reset
  // arrive and are ignored; RUN is entered when the count reaches zero.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      DRAIN: begin
        if (drain_cnt <= DC_W'(1)) begin
          drain_cnt_nxt = '0;
          state_nxt     = RUN;
        end else begin
          drain_cnt_nxt = drain_cnt - DC_W'(1);
        end
      end
      RUN: state_nxt = RUN;
      default: state_nxt = DRAIN;
    endcase
  end

  // Grant: round-robin on ties, blocked while the tracker is full. A pop in
  // the same cycle does not free a slot until the following cycle. Reset
  // masks the readies so nothing looks accepted in a cycle that is discarded.
  always_comb begin
    run_st    = (state == RUN);
    can_grant = run_st && !reset && (inflight < CNT_W'(DEPTH));
    gnt0      = can_grant && req0Valid && (!req1Valid || last_grant);
    gnt1      = can_grant && req1Valid && (!req0Valid || !last_grant);
    gnt_any   = gnt0 || gnt1;
    gnt_id    = gnt1;
    gnt_addr  = gnt1 ? req1Addr : req0Addr;
    gnt_tag   = gnt1 ? req1Tag  : req0Tag;
    push      = gnt_any && (gnt_addr != EMPTY_ADDR);
    pop       = run_st && loadReady && (inflight != '0);
    spurious  = run_st && loadReady && (inflight == '0);
    head_id   = fifo_mem[rd_ptr][TAG_W];
    head_tag  = fifo_mem[rd_ptr][TAG_W-1:0];
    req0Ready = gnt0;
    req1Ready = gnt1;
  end

  // Tracker storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {gnt_id, gnt_tag};
  end

  // Tracker pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      inflight <= inflight + CNT_W'(1);
      else if (pop && !push) inflight <= inflight - CNT_W'(1);
    end
  end

  // Round-robin pointer: moves only when someone is actually granted.
  always_ff @(posedge clk) begin
    if (reset) last_grant <= 1'b1;
    else if (gnt_any) last_grant <= gnt_id;
  end

  // Registered issue to the memory port. The sentinel address is accepted
  // but never issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      loadEnable <= 1'b0;
      loadAddr   <= 16'h0000;
    end else begin
      loadEnable <= push;
      if (push) loadAddr <= gnt_addr;
    end
  end

  // Registered responses, steered by the head of the tracker. Data and tag
  // hold their last value between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0Valid <= 1'b0;
      rsp0Data  <= '0;
      rsp0Tag   <= '0;
      rsp1Valid <= 1'b0;
      rsp1Data  <= '0;
      rsp1Tag   <= '0;
    end else begin
      rsp0Valid <= pop && !head_id;
      rsp1Valid <= pop && head_id;
      if (pop && !head_id) begin
        rsp0Data <= loadData;
        rsp0Tag  <= head_tag;
      end
      if (pop && head_id) begin
        rsp1Data <= loadData;
        rsp1Tag  <= head_tag;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      badAddr  <= 1'b0;
      protoErr <= 1'b0;
    end else begin
      if (gnt_any && (gnt_addr == EMPTY_ADDR)) badAddr <= 1'b1;
      if (spurious) protoErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_port_arbiter.sv
// Bench for load_port_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model and an elastic
// memory model that can withhold results.
module tb_load_port_arbiter;
  localparam int LAT = 3;
  localparam int DEP = 4;
  localparam int TW  = 4;
  localparam int IW  = $clog2(DEP + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0Valid = 0, req1Valid = 0, req0Ready, req1Ready;
  logic [15:0] req0Addr = 0, req1Addr = 0;
  logic [TW-1:0] req0Tag = 0, req1Tag = 0;
  logic loadEnable, loadReady = 0;
  logic [15:0] loadAddr;
  logic [63:0] loadData = 0;
  logic rsp0Valid, rsp1Valid;
  logic [63:0] rsp0Data, rsp1Data;
  logic [TW-1:0] rsp0Tag, rsp1Tag;
  logic [IW-1:0] inflight;
  logic badAddr, protoErr;

  always #5 clk = ~clk;

  load_port_arbiter #(.LATENCY(LAT), .DEPTH(DEP), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Addr(req0Addr), .req0Tag(req0Tag),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Addr(req1Addr), .req1Tag(req1Tag),
    .loadEnable(loadEnable), .loadAddr(loadAddr), .loadReady(loadReady), .loadData(loadData),
    .rsp0Valid(rsp0Valid), .rsp0Data(rsp0Data), .rsp0Tag(rsp0Tag),
    .rsp1Valid(rsp1Valid), .rsp1Data(rsp1Data), .rsp1Tag(rsp1Tag),
    .inflight(inflight), .badAddr(badAddr), .protoErr(protoErr)
  );

  typedef struct {int id; int tag;} trk_t;
  typedef struct {logic [15:0] addr; int due;} mem_t;

  trk_t trk[$];          // loads the arbiter should be tracking, oldest first
  mem_t mq[$];           // loads inside the memory, oldest first
  int total = 0, bad = 0;
  int cyc = 0;
  bit m_run; int m_k; int m_last; bit m_bad, m_perr;
  bit exp_le; logic [15:0] exp_la;
  bit exp_rv[2]; logic [63:0] exp_rd[2]; int exp_rt[2];
  bit after_rst;
  bit stall = 0, release_one = 0, chk_en = 0;
  bit dut_r0, dut_r1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] memword(input logic [15:0] a);
    logic [13:0] w;
    w = a[15:2];
    return {16'hD00D, 2'b00, w, 2'b00, w ^ 14'h2A5A, 16'(w * 7)};
  endfunction

  // One clock cycle: drive inputs after the edge, check at the falling edge,
  // then advance the model across the coming edge.
  task automatic cycle(input bit rst, input bit v0, input logic [15:0] a0, input int t0,
                       input bit v1, input logic [15:0] a1, input int t1, input bit force_lr);
    bit pr0, pr1;
    int sz, g;
    trk_t h;
    @(posedge clk); #1;
    cyc++;
    reset = rst;
    req0Valid = v0; req0Addr = a0; req0Tag = TW'(t0);
    req1Valid = v1; req1Addr = a1; req1Tag = TW'(t1);
    loadReady = 1'b0;
    loadData = {$urandom, $urandom};
    if (force_lr) begin
      loadReady = 1'b1;
    end else if ((!stall || !m_run || release_one) && mq.size() > 0 && mq[0].due <= cyc) begin
      loadReady = 1'b1;
      loadData = memword(mq[0].addr);
      void'(mq.pop_front());
      release_one = 0;
    end

    @(negedge clk);
    sz  = trk.size();
    pr0 = !rst && m_run && v0 && sz < DEP && (!v1 || m_last == 1);
    pr1 = !rst && m_run && v1 && sz < DEP && (!v0 || m_last == 0);
    dut_r0 = req0Ready; dut_r1 = req1Ready;
    if (chk_en) begin
      chk("req0Ready", req0Ready, pr0);
      chk("req1Ready", req1Ready, pr1);
      chk("loadEnable", loadEnable, exp_le);
      if (exp_le || after_rst) chk("loadAddr", loadAddr, exp_la);
      chk("inflight", inflight, sz);
      chk("badAddr", badAddr, m_bad);
      chk("protoErr", protoErr, m_perr);
      chk("rsp0Valid", rsp0Valid, exp_rv[0]);
      chk("rsp1Valid", rsp1Valid, exp_rv[1]);
      if (exp_rv[0] || after_rst) begin
        chk("rsp0Data", rsp0Data, exp_rd[0]);
        chk("rsp0Tag", rsp0Tag, exp_rt[0]);
      end
      if (exp_rv[1] || after_rst) begin
        chk("rsp1Data", rsp1Data, exp_rd[1]);
        chk("rsp1Tag", rsp1Tag, exp_rt[1]);
      end
    end
    // the memory captures whatever the arbiter issues, reset or not
    if (loadEnable === 1'b1) mq.push_back('{loadAddr, cyc + LAT});

    if (rst) begin
      trk.delete();
      m_run = 0; m_k = 0; m_last = 1; m_bad = 0; m_perr = 0;
      exp_le = 0; exp_la = 16'h0000;
      exp_rv = '{0, 0}; exp_rd = '{64'h0, 64'h0}; exp_rt = '{0, 0};
      after_rst = 1;
      // results the memory was withholding are lost; in-pipe ones still return
      while (mq.size() > 0 && mq[0].due <= cyc) void'(mq.pop_front());
    end else begin
      after_rst = 0;
      exp_rv = '{0, 0};
      exp_le = 0;
      if (!m_run) begin
        m_k++;
        if (m_k >= LAT + 1) m_run = 1;
      end else begin
        if (loadReady) begin
          if (trk.size() > 0) begin
            h = trk.pop_front();
            exp_rv[h.id] = 1; exp_rd[h.id] = loadData; exp_rt[h.id] = h.tag;
          end else begin
            m_perr = 1;
          end
        end
        if (pr0 || pr1) begin
          g = pr0 ? 0 : 1;
          m_last = g;
          if ((pr0 ? a0 : a1) == 16'hFFFF) m_bad = 1;
          else begin
            trk.push_back('{g, pr0 ? t0 : t1});
            exp_le = 1;
            exp_la = pr0 ? a0 : a1;
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
  endtask

  initial begin
    int n, gc;
    int seq[$];
    bit v0, v1, rst;
    logic [15:0] a0, a1;

    // reset, with requests already waiting
    cycle(1, 1, 16'h0010, 3, 1, 16'h0020, 1, 0);
    chk_en = 1;
    cycle(1, 1, 16'h0010, 3, 1, 16'h0020, 1, 0);
    chk("rst_state_inflight", inflight, 0);
    chk("rst_state_loadAddr", loadAddr, 0);

    // single req0 held until granted; first grant at cycle LAT+1 after reset
    n = 0;
    while (n < 50) begin
      cycle(0, 1, 16'h0010, 3, 0, 16'h0, 0, 0);
      if (dut_r0) break;
      n++;
    end
    chk("first_grant_cycle", n, LAT + 1);
    n = 1;
    while (n < 50) begin
      cycle(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
      if (rsp0Valid === 1'b1) break;
      n++;
    end
    chk("rsp0_latency", n, LAT + 2);
    chk("rsp0_tag_dir", rsp0Tag, 3);
    chk("rsp0_data_dir", rsp0Data, memword(16'h0010));
    idle(2);
    chk("inflight_back_to_0", inflight, 0);

    // sentinel address on req1: accepted, not issued, flagged
    cycle(0, 0, 16'h0, 0, 1, 16'hFFFF, 5, 0);
    chk("ffff_ready", dut_r1, 1);
    cycle(0, 0, 16'h0, 0, 1, 16'h0040, 6, 0);
    chk("ffff_no_issue", loadEnable, 0);
    chk("ffff_badAddr", badAddr, 1);
    idle(LAT + 4);

    // both valid: grants alternate starting with req0
    gc = 0; n = 0;
    while (seq.size() < 6 && n < 40) begin
      cycle(0, 1, 16'h0100 + 16'(gc * 4), gc, 1, 16'h0200 + 16'(gc * 4), 8 + gc, 0);
      if (dut_r0) begin seq.push_back(0); gc++; end
      if (dut_r1) begin seq.push_back(1); gc++; end
      n++;
    end
    chk("alt_count", seq.size(), 6);
    for (int i = 0; i < seq.size(); i++) chk($sformatf("alt_seq%0d", i), seq[i], i % 2);
    idle(LAT + 6);

    // full tracker: memory withholds results
    stall = 1;
    for (int i = 0; i < 7; i++) cycle(0, 1, 16'h0300 + 16'(i * 4), i, 1, 16'h0400 + 16'(i * 4), i + 7, 0);
    chk("full_inflight", inflight, DEP);
    chk("full_ready0", dut_r0, 0);
    release_one = 1;
    cycle(0, 1, 16'h0340, 1, 1, 16'h0440, 2, 0);
    chk("full_pop_cycle_ready", dut_r0 | dut_r1, 0);
    cycle(0, 1, 16'h0344, 1, 1, 16'h0444, 2, 0);
    chk("full_resume_ready", dut_r0 | dut_r1, 1);
    stall = 0;
    idle(DEP + LAT + 8);

    // reset in the middle of traffic
    for (int i = 0; i < 5; i++) cycle(0, 1, 16'h0500 + 16'(i * 4), i, 0, 16'h0, 0, 0);
    idle(5);
    cycle(1, 0, 16'h0, 0, 0, 16'h0, 0, 0);
    idle(LAT + 2);
    cycle(0, 1, 16'h0600, 9, 0, 16'h0, 0, 0);
    idle(LAT + 4);

    // result with nothing outstanding
    cycle(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
    idle(3);
    chk("protoErr_sticky", protoErr, 1);
    chk("protoErr_inflight", inflight, 0);

    // random traffic with memory stalls and occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      a0 = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      a1 = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      cycle(rst, v0, a0, $urandom_range(0, 15), v1, a1, $urandom_range(0, 15), 0);
    end
    stall = 0;
    idle(DEP + LAT + 12);
    chk("end_inflight", inflight, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_port_arbiter.md
# load_port_arbiter

Arbiter and in-flight tracker for the shared data-memory load port. Two load requesters (e.g. LSU pipes) compete for the single load port, which accepts one address per cycle and returns data exactly LATENCY cycles later, in order, with no tag. The block grants round-robin, registers the issued address, and keeps an ordered FIFO of {requester, tag} so each returning 64-bit block goes back to its owner. It sits between the requesters and the memory's load port.

## Interface
- LATENCY, 100, memory load pipeline depth in cycles.
- DEPTH, 128, maximum in-flight loads. Must be ≥ LATENCY+1.
- TAG_W, 4, width of the requester-supplied tag.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req0Valid / req1Valid  in  1  request present.
- req0Ready / req1Ready  out  1  request accepted this cycle.
- req0Addr / req1Addr  in  16  load address.
- req0Tag / req1Tag  in  TAG_W  opaque tag, returned with the data.
- loadEnable  out  1  issue to the memory load port (registered).
- loadAddr  out  16  issued address (registered).
- loadReady  in  1  memory result valid.
- loadData  in  64  memory result.
- rsp0Valid / rsp1Valid  out  1  one-cycle response pulse (registered).
- rsp0Data / rsp1Data  out  64  returned block.
- rsp0Tag / rsp1Tag  out  TAG_W  tag of the returned request.
- inflight  out  $clog2(DEPTH+1)  count of tracked outstanding loads.
- badAddr  out  1  sticky: a request with address 16'hFFFF was dropped.
- protoErr  out  1  sticky: loadReady seen with an empty tracking FIFO in RUN.

## Operation
- States: DRAIN, RUN. Reset enters DRAIN with drainCnt = LATENCY+1.
- DRAIN: no grants (both ready = 0), loadReady ignored, drainCnt decrements each cycle; at 0 → RUN. This flushes returns belonging to requests issued before reset.
- RUN grant: eligible = inflight < DEPTH. If only one reqNValid is high, grant it. If both are high, grant the requester not granted last. Ready is combinational from valid and state.
- lastGrant updates only on a grant. Reset value = 1, so req0 wins the first tie.
- On a grant with addr ≠ 16'hFFFF: push {id, tag} into the FIFO, set loadEnable = 1 and loadAddr = addr on the next cycle, and increment inflight.
- On a grant with addr == 16'hFFFF (the memory's empty sentinel): the request is accepted and not issued. No push, loadEnable stays 0, and badAddr is set.
- loadReady in RUN with FIFO non-empty: pop the head. Next cycle rspNValid = 1 for the head id, with rspNData = loadData and rspNTag = head tag. Decrement inflight.
- loadReady in RUN with FIFO empty: set protoErr and discard the result.
- A push and a pop in the same cycle leave inflight unchanged. The FIFO is circular with DEPTH entries, and pointers wrap modulo DEPTH.
- No backpressure on responses; requesters must always accept rsp pulses.

## Timing
- Reset values: all readies 0, loadEnable 0, loadAddr 16'h0000, all rspValid 0, rspData 0, rspTag 0, inflight 0, badAddr 0, protoErr 0, state DRAIN, FIFO empty.
- Accept at cycle t → loadEnable high in cycle t+1 → memory captures at edge ending t+1 → loadReady in cycle t+1+LATENCY → rspValid in cycle t+2+LATENCY.
- Throughput is one grant per cycle. Back-to-back grants give back-to-back loadEnable.
- First possible grant is cycle LATENCY+1 after reset deasserts.
- Reset asserted mid-operation: on the next edge the FIFO, inflight, pending loadEnable and error flags are all cleared, then DRAIN runs. No rsp pulses are produced for pre-reset requests.
- When inflight == DEPTH, both readies stay 0 even if a pop occurs in the same cycle. Grants resume the cycle after.

## Test plan
- Reset, then single req0 (addr 16'h0010, tag 3) accepted at cycle T → loadEnable/loadAddr = 16'h0010 at T+1; with the memory model, rsp0Valid with tag 3 and data = memory word 4 at T+2+LATENCY; inflight returns to 0.
- Both requesters valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1; responses return in that order with correct tags on rsp0/rsp1.
- req1 with addr 16'hFFFF → req1Ready = 1, loadEnable stays 0, badAddr = 1, no rsp1 pulse; the next legal request completes normally.
- DEPTH = 4 with a stub memory that withholds loadReady → 4 grants, inflight = 4, readies 0; one loadReady pulse → inflight 3, grant resumes the following cycle.
- Issue 5 loads, assert reset 10 cycles later for 1 cycle → outputs return to reset values, no rsp pulses during DRAIN (LATENCY+1 cycles), protoErr stays 0, and a new request after DRAIN completes normally.
- Force loadReady high in RUN with an empty FIFO → protoErr = 1 (sticky until reset), no rsp pulse.
